// File: rtl/fetch_unit.sv
// Fetch stage: word fetches feed a 4-halfword queue; one 16/32-bit instruction per cycle to decode, registered.
// Static backward-taken prediction; redirects and taken predictions flush the queue and drop in-flight data.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ready_i,
   input  logic        imem_valid_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] instruction_o,
   output logic [31:0] program_counter_o,
   output logic        branch_taken_o,
   output logic        instr_valid_o
);
   logic [31:0] fetch_pc, issue_pc;
   logic [15:0] queue [4];
   logic [1:0]  rd_ptr, wr_ptr;
   logic [2:0]  count;
   logic        outstanding, discard, req_half;

   logic        handshake, resp_push, is32, can_issue, is_jal, is_bwd_br, predict_taken, flush;
   logic [15:0] h0, h1;
   logic [31:0] instr32, j_imm, b_imm, target, new_pc;
   logic [2:0]  push_n, pop_n;

   // Request is withdrawn combinationally while a redirect is present.
   assign imem_req_o  = rst_i && !outstanding && (count <= 3'd2) && !redirect_i;
   assign imem_addr_o = {fetch_pc[31:2], 2'b00};
   assign handshake   = imem_req_o && imem_ready_i;
   assign resp_push   = imem_valid_i && outstanding && !discard;

   assign h0        = queue[rd_ptr];
   assign h1        = queue[rd_ptr + 2'd1];
   assign instr32   = {h1, h0};
   assign is32      = (h0[1:0] == 2'b11);
   assign can_issue = !redirect_i && !stall_i && (is32 ? (count >= 3'd2) : (count >= 3'd1));

   assign j_imm = {{12{instr32[31]}}, instr32[19:12], instr32[20], instr32[30:21], 1'b0};
   assign b_imm = {{20{instr32[31]}}, instr32[7], instr32[30:25], instr32[11:8], 1'b0};
   assign is_jal        = is32 && (instr32[6:0] == 7'b1101111);
   assign is_bwd_br     = is32 && (instr32[6:0] == 7'b1100011) && instr32[31];
   assign predict_taken = is_jal || is_bwd_br;
   assign target        = issue_pc + (is_jal ? j_imm : b_imm);

   assign flush  = redirect_i || (can_issue && predict_taken);
   assign new_pc = redirect_i ? {redirect_pc_i[31:1], 1'b0} : target;
   assign push_n = resp_push ? (req_half ? 3'd1 : 3'd2) : 3'd0;
   assign pop_n  = can_issue ? (is32 ? 3'd2 : 3'd1) : 3'd0;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         fetch_pc    <= RESET_PC;
         issue_pc    <= RESET_PC;
         rd_ptr      <= 2'd0;
         wr_ptr      <= 2'd0;
         count       <= 3'd0;
         outstanding <= 1'b0;
         discard     <= 1'b0;
         req_half    <= 1'b0;
      end else begin
         if (handshake) begin
            outstanding <= 1'b1;
            req_half    <= fetch_pc[1];
         end else if (imem_valid_i && outstanding) begin
            outstanding <= 1'b0;
         end

         // A flush marks any in-flight request (including one accepted this cycle) as stale.
         if (flush)
            discard <= handshake || (outstanding && !imem_valid_i);
         else if (imem_valid_i && outstanding)
            discard <= 1'b0;

         if (flush)
            fetch_pc <= new_pc;
         else if (handshake)
            fetch_pc <= {fetch_pc[31:2], 2'b00} + 32'd4;

         if (flush) begin
            issue_pc <= new_pc;
            rd_ptr   <= 2'd0;
            wr_ptr   <= 2'd0;
            count    <= 3'd0;
         end else begin
            if (can_issue)
               issue_pc <= issue_pc + (is32 ? 32'd4 : 32'd2);
            rd_ptr <= rd_ptr + pop_n[1:0];
            wr_ptr <= wr_ptr + push_n[1:0];
            count  <= count + push_n - pop_n;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (resp_push && !flush) begin
         if (req_half) begin
            queue[wr_ptr] <= imem_rdata_i[31:16];
         end else begin
            queue[wr_ptr]        <= imem_rdata_i[15:0];
            queue[wr_ptr + 2'd1] <= imem_rdata_i[31:16];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         instruction_o     <= NOP_INSTR;
         program_counter_o <= 32'd0;
         branch_taken_o    <= 1'b0;
         instr_valid_o     <= 1'b0;
      end else if (redirect_i || (!stall_i && !can_issue)) begin
         instruction_o  <= NOP_INSTR;
         branch_taken_o <= 1'b0;
         instr_valid_o  <= 1'b0;
      end else if (can_issue) begin
         instruction_o     <= is32 ? instr32 : {16'h0000, h0};
         program_counter_o <= issue_pc;
         branch_taken_o    <= predict_taken;
         instr_valid_o     <= 1'b1;
      end
   end
endmodule
